sdram_cmd_arbiter: RTL
======================

SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 1560, sets the refresh period in clk cycles (15.6 us at 100 MHz).
REQ-002 Parameter QUANTUM, default 64, sets the maximum cycles a grant is held while the other engine is requesting.
REQ-003 Port clk, input, 1 bit: SDRAM clock; all state updates on falling edge, same as the engines.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Ports wr_req / rd_req, input, 1 bit each: engine has work (write FIFO not empty / read FIFO not full and read pending).
REQ-006 Ports wr_ready / rd_ready and wr_busy / rd_busy, input, 1 bit each: engine idle-with-zero-delay, and engine mid-transfer (writing/reading).
REQ-007 Ports wr_en / rd_en, output, 1 bit each: grant to the engine.
REQ-008 Port auto_refresh, output, 1 bit: single-cycle refresh pulse to the granted engine.
REQ-009 Ports wr_command/rd_command (3), wr_addr/rd_addr (12), wr_bank/rd_bank (2), wr_data/rd_data (16), wr_dqm/rd_dqm (2), input: per-engine SDRAM pin drive.
REQ-010 Ports sd_command (3), sd_addr (12), sd_bank (2), sd_data_out (16), sd_dqm (2), output: muxed SDRAM pins.
REQ-011 Port owner, output, 2 bits: 0 none, 1 write, 2 read.

Function
REQ-012 States: IDLE, GRANT_WR, GRANT_RD, DRAIN, REFRESH.
REQ-013 IDLE: refresh_pending has priority and moves to REFRESH; else one requester moves to that GRANT state; both requesting resolves round-robin against last_owner (starting with write after reset).
REQ-014 GRANT_x: en_x held high; quantum counter increments each cycle while the other engine requests and otherwise clears.
REQ-015 GRANT_x exits to DRAIN on the first of: req_x low, quantum counter == QUANTUM-1, refresh_pending set with busy_x low.
REQ-016 DRAIN: en_x low; return to IDLE when busy_x low and ready_x high in the same cycle; last_owner updated on this exit.
REQ-017 Refresh counter: free-running 0..REFRESH_INTERVAL-1 with wrap; wrap sets refresh_pending.
REQ-018 If GRANT_x is active at wrap, auto_refresh pulses one cycle together with en_x and pending clears; the engine performs the refresh.
REQ-019 REFRESH: wr_en and auto_refresh high for exactly one cycle, pending cleared, then wait for wr_ready low followed by wr_ready high, then IDLE.
REQ-020 Wrap coinciding with an existing pending refresh: pending stays set; a refresh is never counted twice or lost.
REQ-021 Pin mux is combinational on owner; owner 0 drives sd_command = NOP, addr/bank/data/dqm = 0.
REQ-022 owner holds its engine value through DRAIN and REFRESH, so pins follow the engine until release.
REQ-023 wr_en and rd_en are never high in the same cycle.

Reset
REQ-024 rst: state IDLE, wr_en = rd_en = auto_refresh = 0, owner 0, refresh counter 0, pending 0, quantum counter 0, last_owner read (so write wins first).
REQ-025 rst mid-grant takes effect next falling edge with no drain; engines are reset by the same rst.

Configuration
REQ-026 Macro SDRAM_ARB_FIXED_PRIO_EN: when defined, simultaneous requests in IDLE always grant read and the QUANTUM limit applies only to write grants; when undefined, round-robin per REQ-013/014.

Structure
REQ-027 State encodings, owner codes and SDRAM command codes (NOP, AR, etc.) belong in the shared sdram include/package.
REQ-028 Sub-module sdram_refresh_timer (counter plus pending flag, clear input) is natural; the mux stays inline.

Verification
REQ-029 Write only: wr_req=1 for 10 cycles -> wr_en rises 1 cycle after, owner=1, sd_command mirrors wr_command, DRAIN then IDLE after wr_busy falls.
REQ-030 Both requesting continuously, QUANTUM=64 -> grants alternate W,R,W; each grant 64 cycles plus drain; rd_en and wr_en never overlap.
REQ-031 Idle with REFRESH_INTERVAL=100 -> auto_refresh and wr_en pulse together at cycle 99; arbiter holds REFRESH until wr_ready low-then-high; repeats at 199.
REQ-032 Read grant active at wrap -> auto_refresh pulses with rd_en high, no REFRESH state entered.
REQ-033 rst asserted during GRANT_RD -> next edge rd_en=0, owner=0, sd_command=NOP; refresh counter restarts at 0.
REQ-034 With SDRAM_ARB_FIXED_PRIO_EN defined, simultaneous requests -> read granted first every time.

Source files
------------

// File: rtl/sdram_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_cmd_arbiter_pkg
// Purpose  : Shared definitions for the SDRAM command arbiter: arbiter state
//            encoding, bus-owner codes, SDRAM command codes ({RAS#,CAS#,WE#})
//            and the round-robin helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sdram_cmd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT_WR = 3'd1,
        ST_GRANT_RD = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_REFRESH  = 3'd4
    } arb_state_t;

    localparam logic [1:0] c_OWNER_NONE = 2'd0;
    localparam logic [1:0] c_OWNER_WR   = 2'd1;
    localparam logic [1:0] c_OWNER_RD   = 2'd2;

    localparam logic [2:0] c_CMD_LOAD_MODE    = 3'b000;
    localparam logic [2:0] c_CMD_AUTO_REFRESH = 3'b001;
    localparam logic [2:0] c_CMD_PRECHARGE    = 3'b010;
    localparam logic [2:0] c_CMD_ACTIVE       = 3'b011;
    localparam logic [2:0] c_CMD_WRITE        = 3'b100;
    localparam logic [2:0] c_CMD_READ         = 3'b101;
    localparam logic [2:0] c_CMD_BURST_TERM   = 3'b110;
    localparam logic [2:0] c_CMD_NOP          = 3'b111;

    // Round-robin winner when both engines request: whoever did not own the
    // bus last. A reset value of "read" makes write win the first contest.
    function automatic logic [1:0] rr_pick(input logic [1:0] last_owner);
        return (last_owner == c_OWNER_WR) ? c_OWNER_RD : c_OWNER_WR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_cmd_arbiter_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_cmd_arbiter_refresh_timer
// Purpose  : Free-running refresh interval counter (0..REFRESH_INTERVAL-1)
//            with a sticky pending flag. o_wrap is high during the last count
//            so the arbiter can act on the wrap at the same edge; the flag
//            remembers a wrap that was not consumed.
// Ports    : clk        - SDRAM clock, falling-edge active
//            rst        - synchronous active-high reset
//            i_clear    - consume the outstanding refresh (pending and/or wrap)
//            o_wrap     - counter is at its terminal value this cycle
//            o_pending  - an earlier wrap has not yet been consumed
// Revision : 1.0 - initial release
// ============================================================================
module sdram_cmd_arbiter_refresh_timer #(
    parameter int REFRESH_INTERVAL = 1560
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_wrap,
    output logic o_pending
);

    localparam int c_CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(REFRESH_INTERVAL - 1);

    logic [c_CW-1:0] r_count;
    logic            r_pending;
    logic            w_wrap;

    assign w_wrap = (r_count == c_LAST);

    always_ff @(negedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
            // A wrap landing on an unconsumed refresh merges into it; a clear
            // consumes whatever is outstanding, including a coincident wrap.
            r_pending <= i_clear ? 1'b0 : (r_pending | w_wrap);
        end
    end

    assign o_wrap    = w_wrap;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_cmd_arbiter
// Purpose  : Arbitrates the SDRAM pins between a write engine and a read
//            engine, schedules periodic auto-refresh and muxes the engine pin
//            drive onto the SDRAM bus according to the current owner.
// Config   : SDRAM_ARB_FIXED_PRIO_EN - when defined, simultaneous requests
//            always grant read and only write grants are quantum-limited.
//            Undefined (default): round-robin, both grants quantum-limited.
// Ports    : clk, rst                  - falling-edge clock, sync high reset
//            wr_req/rd_req             - engine has work
//            wr_ready/rd_ready         - engine idle with zero delay
//            wr_busy/rd_busy           - engine mid-transfer
//            wr_en/rd_en               - grant to engine
//            auto_refresh              - one-cycle refresh pulse to grantee
//            wr_*/rd_* pin drive       - command/addr/bank/data/dqm per engine
//            sd_*                      - muxed SDRAM pins
//            owner                     - 0 none, 1 write, 2 read
// Revision : 1.0 - initial release
// ============================================================================
module sdram_cmd_arbiter
    import sdram_cmd_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 1560,
    parameter int QUANTUM          = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        wr_ready,
    input  logic        rd_ready,
    input  logic        wr_busy,
    input  logic        rd_busy,
    output logic        wr_en,
    output logic        rd_en,
    output logic        auto_refresh,
    input  logic [2:0]  wr_command,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_dqm,
    input  logic [2:0]  rd_command,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    input  logic [15:0] rd_data,
    input  logic [1:0]  rd_dqm,
    output logic [2:0]  sd_command,
    output logic [11:0] sd_addr,
    output logic [1:0]  sd_bank,
    output logic [15:0] sd_data_out,
    output logic [1:0]  sd_dqm,
    output logic [1:0]  owner
);

    localparam int c_QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [c_QW-1:0] c_Q_LAST = c_QW'(QUANTUM - 1);

    arb_state_t      r_state,        w_state_next;
    logic            r_wr_en,        w_wr_en_next;
    logic            r_rd_en,        w_rd_en_next;
    logic            r_auto_refresh, w_ar_next;
    logic [1:0]      r_owner,        w_owner_next;
    logic [1:0]      r_last_owner,   w_last_next;
    logic [c_QW-1:0] r_qcnt,         w_qcnt_next;
    logic            r_ref_low,      w_ref_low_next;

    logic            w_wrap;
    logic            w_pending;
    logic            w_refresh_req;
    logic            w_timer_clear;

    logic            w_is_rd_grant;
    logic            w_g_req;
    logic            w_g_busy;
    logic            w_other_req;
    logic            w_q_limit_en;
    logic            w_q_expired;
    logic            w_d_busy;
    logic            w_d_ready;
    logic [1:0]      w_pick;

    sdram_cmd_arbiter_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timer_clear),
        .o_wrap    (w_wrap),
        .o_pending (w_pending)
    );

    // The wrap is acted on at the edge it occurs, so a refresh request is
    // either an older pending one or the wrap happening right now.
    assign w_refresh_req = w_pending | w_wrap;

    // Signals of the engine currently granted (only meaningful in GRANT_x).
    assign w_is_rd_grant = (r_state == ST_GRANT_RD);
    assign w_g_req       = w_is_rd_grant ? rd_req  : wr_req;
    assign w_g_busy      = w_is_rd_grant ? rd_busy : wr_busy;
    assign w_other_req   = w_is_rd_grant ? wr_req  : rd_req;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign w_q_limit_en = ~w_is_rd_grant;
`else
    assign w_q_limit_en = 1'b1;
`endif
    assign w_q_expired = w_q_limit_en && (r_qcnt == c_Q_LAST);

    // Owner is held through DRAIN, so it identifies the engine being drained.
    assign w_d_busy  = (r_owner == c_OWNER_RD) ? rd_busy  : wr_busy;
    assign w_d_ready = (r_owner == c_OWNER_RD) ? rd_ready : wr_ready;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wr_en        <= 1'b0;
            r_rd_en        <= 1'b0;
            r_auto_refresh <= 1'b0;
            r_owner        <= c_OWNER_NONE;
            r_last_owner   <= c_OWNER_RD;
            r_qcnt         <= '0;
            r_ref_low      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_wr_en        <= w_wr_en_next;
            r_rd_en        <= w_rd_en_next;
            r_auto_refresh <= w_ar_next;
            r_owner        <= w_owner_next;
            r_last_owner   <= w_last_next;
            r_qcnt         <= w_qcnt_next;
            r_ref_low      <= w_ref_low_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_wr_en_next   = 1'b0;
        w_rd_en_next   = 1'b0;
        w_ar_next      = 1'b0;
        w_owner_next   = r_owner;
        w_last_next    = r_last_owner;
        w_qcnt_next    = '0;
        w_ref_low_next = r_ref_low;
        w_timer_clear  = 1'b0;
        w_pick         = c_OWNER_NONE;

        case (r_state)
            ST_IDLE: begin
                w_owner_next   = c_OWNER_NONE;
                w_ref_low_next = 1'b0;
                if (w_refresh_req) begin
                    // Refresh is executed by the write engine.
                    w_state_next  = ST_REFRESH;
                    w_wr_en_next  = 1'b1;
                    w_ar_next     = 1'b1;
                    w_owner_next  = c_OWNER_WR;
                    w_timer_clear = 1'b1;
                end else begin
                    if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                        w_pick = c_OWNER_RD;
`else
                        w_pick = rr_pick(r_last_owner);
`endif
                    end else if (wr_req) begin
                        w_pick = c_OWNER_WR;
                    end else if (rd_req) begin
                        w_pick = c_OWNER_RD;
                    end

                    if (w_pick == c_OWNER_WR) begin
                        w_state_next = ST_GRANT_WR;
                        w_wr_en_next = 1'b1;
                        w_owner_next = c_OWNER_WR;
                    end else if (w_pick == c_OWNER_RD) begin
                        w_state_next = ST_GRANT_RD;
                        w_rd_en_next = 1'b1;
                        w_owner_next = c_OWNER_RD;
                    end
                end
            end

            ST_GRANT_WR, ST_GRANT_RD: begin
                if (!w_g_req || w_q_expired || (w_pending && !w_g_busy)) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_wr_en_next = ~w_is_rd_grant;
                    w_rd_en_next = w_is_rd_grant;
                    if (w_q_limit_en && w_other_req) begin
                        w_qcnt_next = r_qcnt + 1'b1;
                    end
                    // A wrap during a continuing grant is handed to the
                    // granted engine; if the grant is ending instead, the
                    // wrap stays pending and REFRESH runs after release.
                    if (w_wrap) begin
                        w_ar_next     = 1'b1;
                        w_timer_clear = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (!w_d_busy && w_d_ready) begin
                    w_state_next = ST_IDLE;
                    w_last_next  = r_owner;
                    w_owner_next = c_OWNER_NONE;
                end
            end

            ST_REFRESH: begin
                // First cycle is the pulse; afterwards wait for the write
                // engine to go not-ready and then ready again.
                if (!r_auto_refresh) begin
                    if (!r_ref_low) begin
                        if (!wr_ready) begin
                            w_ref_low_next = 1'b1;
                        end
                    end else if (wr_ready) begin
                        w_state_next   = ST_IDLE;
                        w_owner_next   = c_OWNER_NONE;
                        w_ref_low_next = 1'b0;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_owner_next = c_OWNER_NONE;
            end
        endcase
    end

    always_comb begin
        sd_command  = c_CMD_NOP;
        sd_addr     = '0;
        sd_bank     = '0;
        sd_data_out = '0;
        sd_dqm      = '0;
        case (r_owner)
            c_OWNER_WR: begin
                sd_command  = wr_command;
                sd_addr     = wr_addr;
                sd_bank     = wr_bank;
                sd_data_out = wr_data;
                sd_dqm      = wr_dqm;
            end
            c_OWNER_RD: begin
                sd_command  = rd_command;
                sd_addr     = rd_addr;
                sd_bank     = rd_bank;
                sd_data_out = rd_data;
                sd_dqm      = rd_dqm;
            end
            default: begin
            end
        endcase
    end

    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign auto_refresh = r_auto_refresh;
    assign owner        = r_owner;

endmodule
`default_nettype wire
